// File: rtl/pc_sequencer_pkg.sv
// A09 shared definitions: command codes, sequencer states, address width.
package a09_pkg;

   localparam int A09_ADDR_W = 16;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_INC = 3'd1,
      CMD_BRA = 3'd2,
      CMD_JMP = 3'd3,
      CMD_CALL = 3'd4,
      CMD_RET = 3'd5,
      CMD_VEC = 3'd6,
      CMD_RSV = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FAULT = 2'd2
   } seq_state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO for CALL/RET.
// Push and pop update on the clock edge; the top entry is read combinationally.
module return_stack #(
   parameter int Width = 16,
   parameter int Depth = 8,
   parameter int LW = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   localparam int AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [LW-1:0]    level_q, level_d;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LW'(Depth));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // At full depth the low bits wrap to 0, so minus one still names the top.
   assign wr_idx  = level_q[AW-1:0];
   assign rd_idx  = wr_idx - AW'(1);
   assign data_o  = mem_q[rd_idx];
   assign level_o = level_q;

   always_comb begin
      level_d = level_q;
      if (do_push) begin
         level_d = level_q + LW'(1);
      end else if (do_pop) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address sequencer for the A09 PC register, with a return stack.
// Loads are issued as a registered NextPC plus a one-cycle active-low LD.
module pc_sequencer
   import a09_pkg::*;
#(
   parameter int DataWidth = A09_ADDR_W,
   parameter int StackDepth = 8,
   parameter logic [DataWidth-1:0] ResetVector = '0
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          CmdValid,
   input  logic [2:0]                    Cmd,
   input  logic [DataWidth-1:0]          Operand,
   input  logic [DataWidth-1:0]          PCIn,
   output logic                          Ready,
   output logic [DataWidth-1:0]          NextPC,
   output logic                          LD,
   output logic                          Fault,
   output logic                          Overflow,
   output logic                          Underflow,
   output logic [$clog2(StackDepth):0]   StackLevel
);

   localparam int LvlW = $clog2(StackDepth) + 1;

   seq_state_e           state_q, state_d;
   logic [DataWidth-1:0] next_pc_q, next_pc_d;
   logic                 ld_q, ld_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic                 push, pop;
   logic                 stk_full, stk_empty;
   logic [DataWidth-1:0] stk_top;
   logic [DataWidth-1:0] pc_inc;
   logic [LvlW-1:0]      stk_level;
   cmd_e                 cmd;

   assign cmd    = cmd_e'(Cmd);
   assign pc_inc = PCIn + DataWidth'(1);

   return_stack #(
      .Width(DataWidth),
      .Depth(StackDepth),
      .LW(LvlW)
   ) u_stack (
      .clk_i  (Clk),
      .rst_ni (Reset),
      .push_i (push),
      .pop_i  (pop),
      .data_i (pc_inc),
      .data_o (stk_top),
      .full_o (stk_full),
      .empty_o(stk_empty),
      .level_o(stk_level)
   );

   always_comb begin
      state_d   = state_q;
      next_pc_d = next_pc_q;
      ld_d      = 1'b1;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push      = 1'b0;
      pop       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (CmdValid) begin
               unique case (cmd)
                  CMD_INC: begin
                     next_pc_d = pc_inc;
                     ld_d      = 1'b0;
                     state_d   = ST_ISSUE;
                  end
                  CMD_BRA: begin
                     next_pc_d = PCIn + Operand;
                     ld_d      = 1'b0;
                     state_d   = ST_ISSUE;
                  end
                  CMD_JMP: begin
                     next_pc_d = Operand;
                     ld_d      = 1'b0;
                     state_d   = ST_ISSUE;
                  end
                  CMD_CALL: begin
                     if (stk_full) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FAULT;
                     end else begin
                        push      = 1'b1;
                        next_pc_d = Operand;
                        ld_d      = 1'b0;
                        state_d   = ST_ISSUE;
                     end
                  end
                  CMD_RET: begin
                     if (stk_empty) begin
                        unf_d   = 1'b1;
                        state_d = ST_FAULT;
                     end else begin
                        pop       = 1'b1;
                        next_pc_d = stk_top;
                        ld_d      = 1'b0;
                        state_d   = ST_ISSUE;
                     end
                  end
                  CMD_VEC: begin
                     next_pc_d = ResetVector;
                     ld_d      = 1'b0;
                     state_d   = ST_ISSUE;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end
         end
         ST_ISSUE: state_d = ST_IDLE;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         next_pc_q <= '0;
         ld_q      <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         next_pc_q <= next_pc_d;
         ld_q      <= ld_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign Ready      = (state_q == ST_IDLE);
   assign Fault      = (state_q == ST_FAULT);
   assign NextPC     = next_pc_q;
   assign LD         = ld_q;
   assign Overflow   = ovf_q;
   assign Underflow  = unf_q;
   assign StackLevel = stk_level;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: pc_sequencer driving a behavioural 16-bit PC register.
module tb_pc_sequencer;

   localparam logic [15:0] RVEC = 16'h0100;

   logic        Clk;
   logic        Reset;
   logic        CmdValid;
   logic [2:0]  Cmd;
   logic [15:0] Operand;
   logic [15:0] PCIn;
   logic        Ready;
   logic [15:0] NextPC;
   logic        LD;
   logic        Fault;
   logic        Overflow;
   logic        Underflow;
   logic [3:0]  StackLevel;
   logic [15:0] pc_q;

   int pass = 0;
   int total = 0;

   pc_sequencer #(
      .DataWidth(16),
      .StackDepth(8),
      .ResetVector(RVEC)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .CmdValid  (CmdValid),
      .Cmd       (Cmd),
      .Operand   (Operand),
      .PCIn      (PCIn),
      .Ready     (Ready),
      .NextPC    (NextPC),
      .LD        (LD),
      .Fault     (Fault),
      .Overflow  (Overflow),
      .Underflow (Underflow),
      .StackLevel(StackLevel)
   );

   // PC register: loads DIn when LD is low
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) pc_q <= '0;
      else if (!LD) pc_q <= NextPC;
   end
   assign PCIn = pc_q;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input logic [2:0] c, input logic [15:0] op);
      int n = 0;
      while (!Ready && n < 20) begin
         step();
         n++;
      end
      if (!Ready) begin
         total++;
         $display("FAIL send_timeout: Ready=%b required 1", Ready);
      end
      CmdValid = 1'b1;
      Cmd = c;
      Operand = op;
      step();
      CmdValid = 1'b0;
   endtask

   task automatic pulse_reset();
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #2 Reset = 1'b0;
      step();
      total++; if (LD !== 1'b1) $display("FAIL rst_ld: got %b need 1", LD); else pass++;
      total++; if (NextPC !== 16'h0000) $display("FAIL rst_npc: got %h need 0000", NextPC); else pass++;
      total++; if ({Fault, Overflow, Underflow} !== 3'b000) $display("FAIL rst_flags: got %b need 000", {Fault, Overflow, Underflow}); else pass++;
      total++; if (StackLevel !== 4'd0) $display("FAIL rst_level: got %0d need 0", StackLevel); else pass++;
      Reset = 1'b1;
      step();
      total++; if (Ready !== 1'b1) $display("FAIL rst_ready: got %b need 1", Ready); else pass++;
   endtask

   task automatic test_inc();
      for (int i = 1; i <= 3; i++) begin
         send(3'd1, 16'h0000);
         total++; if ({LD, Ready} !== 2'b00) $display("FAIL inc_issue%0d: LD,Ready=%b need 00", i, {LD, Ready}); else pass++;
         step();
         total++; if (pc_q !== 16'(i)) $display("FAIL inc_pc%0d: got %h need %h", i, pc_q, 16'(i)); else pass++;
         total++; if ({LD, Ready} !== 2'b11) $display("FAIL inc_idle%0d: LD,Ready=%b need 11", i, {LD, Ready}); else pass++;
      end
   endtask

   task automatic test_nop();
      send(3'd0, 16'h1234);
      total++; if ({LD, Ready} !== 2'b11) $display("FAIL nop: LD,Ready=%b need 11", {LD, Ready}); else pass++;
      send(3'd7, 16'h1234);
      total++; if ({LD, Ready} !== 2'b11) $display("FAIL rsv: LD,Ready=%b need 11", {LD, Ready}); else pass++;
      total++; if (pc_q !== 16'h0003) $display("FAIL nop_pc: got %h need 0003", pc_q); else pass++;
   endtask

   task automatic test_jmp_bra();
      send(3'd3, 16'h00A0);
      step();
      total++; if (pc_q !== 16'h00A0) $display("FAIL jmp: got %h need 00a0", pc_q); else pass++;
      send(3'd2, 16'hFFF0);
      step();
      total++; if (pc_q !== 16'h0090) $display("FAIL bra_neg: got %h need 0090", pc_q); else pass++;
      send(3'd3, 16'hFFFF);
      step();
      total++; if (pc_q !== 16'hFFFF) $display("FAIL jmp_ffff: got %h need ffff", pc_q); else pass++;
      send(3'd1, 16'h0000);
      step();
      total++; if (pc_q !== 16'h0000) $display("FAIL inc_wrap: got %h need 0000", pc_q); else pass++;
   endtask

   task automatic test_call_ret();
      send(3'd3, 16'h0010);
      step();
      send(3'd4, 16'h0200);
      total++; if (StackLevel !== 4'd1) $display("FAIL call1_lvl: got %0d need 1", StackLevel); else pass++;
      step();
      total++; if (pc_q !== 16'h0200) $display("FAIL call1_pc: got %h need 0200", pc_q); else pass++;
      send(3'd4, 16'h0300);
      total++; if (StackLevel !== 4'd2) $display("FAIL call2_lvl: got %0d need 2", StackLevel); else pass++;
      step();
      total++; if (pc_q !== 16'h0300) $display("FAIL call2_pc: got %h need 0300", pc_q); else pass++;
      send(3'd5, 16'h0000);
      total++; if (StackLevel !== 4'd1) $display("FAIL ret1_lvl: got %0d need 1", StackLevel); else pass++;
      step();
      total++; if (pc_q !== 16'h0201) $display("FAIL ret1_pc: got %h need 0201", pc_q); else pass++;
      send(3'd5, 16'h0000);
      total++; if (StackLevel !== 4'd0) $display("FAIL ret2_lvl: got %0d need 0", StackLevel); else pass++;
      step();
      total++; if (pc_q !== 16'h0011) $display("FAIL ret2_pc: got %h need 0011", pc_q); else pass++;
   endtask

   task automatic test_overflow();
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         send(3'd4, 16'h1000 + 16'(i));
         total++; if (LD !== 1'b0) $display("FAIL ovf_call%0d_ld: got %b need 0", i, LD); else pass++;
         step();
         total++; if (pc_q !== 16'h1000 + 16'(i)) $display("FAIL ovf_call%0d_pc: got %h need %h", i, pc_q, 16'h1000 + 16'(i)); else pass++;
      end
      send(3'd4, 16'h2000);
      total++; if (LD !== 1'b1) $display("FAIL ovf_ld: got %b need 1", LD); else pass++;
      total++; if ({Overflow, Fault, Ready, Underflow} !== 4'b1100) $display("FAIL ovf_flags: OFRU=%b need 1100", {Overflow, Fault, Ready, Underflow}); else pass++;
      total++; if (StackLevel !== 4'd8) $display("FAIL ovf_lvl: got %0d need 8", StackLevel); else pass++;
      CmdValid = 1'b1;
      Cmd = 3'd3;
      Operand = 16'h3333;
      step();
      step();
      step();
      CmdValid = 1'b0;
      total++; if ({pc_q, LD} !== {16'h1007, 1'b1}) $display("FAIL ovf_ignore: pc=%h LD=%b need 1007/1", pc_q, LD); else pass++;
      total++; if ({Fault, Overflow, Ready} !== 3'b110) $display("FAIL ovf_sticky: FOR=%b need 110", {Fault, Overflow, Ready}); else pass++;
   endtask

   task automatic test_underflow();
      pulse_reset();
      send(3'd5, 16'h0000);
      total++; if ({Underflow, Fault, LD, Overflow} !== 4'b1110) $display("FAIL unf_flags: UFLO=%b need 1110", {Underflow, Fault, LD, Overflow}); else pass++;
      step();
      total++; if ({pc_q, StackLevel} !== {16'h0000, 4'd0}) $display("FAIL unf_state: pc=%h lvl=%0d need 0000/0", pc_q, StackLevel); else pass++;
      pulse_reset();
      total++; if ({Fault, Overflow, Underflow, Ready} !== 4'b0001) $display("FAIL unf_clear: FOUR=%b need 0001", {Fault, Overflow, Underflow, Ready}); else pass++;
      total++; if (StackLevel !== 4'd0) $display("FAIL unf_clear_lvl: got %0d need 0", StackLevel); else pass++;
   endtask

   task automatic test_reset_mid_issue();
      send(3'd3, 16'h0055);
      total++; if ({LD, NextPC} !== {1'b0, 16'h0055}) $display("FAIL mid_issue: LD=%b npc=%h need 0/0055", LD, NextPC); else pass++;
      #2 Reset = 1'b0;
      #1;
      total++; if ({LD, NextPC} !== {1'b1, 16'h0000}) $display("FAIL mid_async: LD=%b npc=%h need 1/0000", LD, NextPC); else pass++;
      step();
      Reset = 1'b1;
      step();
      total++; if (pc_q !== 16'h0000) $display("FAIL mid_noload: got %h need 0000", pc_q); else pass++;
      send(3'd6, 16'h0000);
      total++; if ({LD, NextPC} !== {1'b0, RVEC}) $display("FAIL vec_issue: LD=%b npc=%h need 0/%h", LD, NextPC, RVEC); else pass++;
      step();
      total++; if (pc_q !== RVEC) $display("FAIL vec_pc: got %h need %h", pc_q, RVEC); else pass++;
   endtask

   initial begin
      Reset = 1'b1;
      CmdValid = 1'b0;
      Cmd = 3'd0;
      Operand = 16'h0000;
      test_reset();
      test_inc();
      test_nop();
      test_jmp_bra();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_reset_mid_issue();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address sequencer for the A09 program counter. It sits directly upstream of the 16-bit PC `Register`: it accepts one control command at a time, computes the next PC from the PC register's current output, and drives that register's `DIn` and active-low `LD`. It holds a small return-address stack for CALL/RET. Stack overflow or underflow is reported as a sticky fault.

## Interface
Parameters:
- `DataWidth`, 16: address width; must match the PC register.
- `StackDepth`, 8: return-stack entries, power of two, at least 2.
- `ResetVector`, 16'h0000: address loaded by the VEC command.

Ports:
- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `CmdValid`  in  1  command present, active-high.
- `Cmd`  in  3  command code; encodings below.
- `Operand`  in  DataWidth  jump target or signed branch offset.
- `PCIn`  in  DataWidth  current PC; wired to PC register `DOut`.
- `Ready`  out  1  high when a command can be accepted.
- `NextPC`  out  DataWidth  wired to PC register `DIn`.
- `LD`  out  1  active-low load strobe to the PC register.
- `Fault`  out  1  sticky error flag.
- `Overflow`  out  1  sticky; set by CALL on a full stack.
- `Underflow`  out  1  sticky; set by RET on an empty stack.
- `StackLevel`  out  clog2(StackDepth)+1  number of occupied entries.

## Operation
- A command is accepted on the rising edge where `CmdValid && Ready`. Commands presented while `Ready` is low are ignored and are not queued.
- Command encodings and their effects:
  - NOP (0): no load.
  - INC (1): NextPC = PCIn + 1.
  - BRA (2): NextPC = PCIn + Operand. Operand is two's complement and the result wraps modulo 2^DataWidth.
  - JMP (3): NextPC = Operand.
  - CALL (4): push PCIn + 1 (wraps), then NextPC = Operand.
  - RET (5): pop the top entry; NextPC = popped value.
  - VEC (6): NextPC = ResetVector.
  - 7: reserved; treated as NOP.
- All additions are DataWidth bits wide; carry-out is discarded.
- FSM states:
  - IDLE: `Ready`=1. An accepted load command moves to ISSUE. NOP or 7 stays in IDLE. CALL on a full stack or RET on an empty stack moves to FAULT.
  - ISSUE: `Ready`=0, `LD`=0, `NextPC` held stable. Unconditionally returns to IDLE on the next edge.
  - FAULT: `Ready`=0, `LD`=1, `Fault`=1. The only exit is `Reset`.
- Stack behaviour:
  - The push happens on the acceptance edge. The pushed entry is readable by a RET in any later command.
  - A CALL at full depth does not push, does not load, and sets `Overflow`. The existing stack contents are preserved.
  - A RET on an empty stack does not pop, does not load, and sets `Underflow`.
  - `StackLevel` ranges over 0..StackDepth.
- Reset values (asynchronous, `Reset`=0): state=IDLE, `NextPC`=0, `LD`=1, `Ready`=1 after release, `Fault`=`Overflow`=`Underflow`=0, `StackLevel`=0. Stack RAM contents are don't-care.
- Reset asserted mid-ISSUE: `LD` returns to 1 immediately (asynchronously). No partial load is required.

## Timing
- Edge k: command accepted. `NextPC` and `LD` are registered and valid after edge k.
- Edge k+1: the PC register captures `NextPC`. The sequencer returns to IDLE. `PCIn` shows the new value after this edge.
- Throughput: one load command per 2 cycles. NOP takes 1 cycle.
- `Ready` is a registered decode of the state; there is no combinational path from `CmdValid` to `Ready`.
- `PCIn` is sampled only on the acceptance edge. Because the ISSUE cycle blocks new commands, a stale-PC read cannot occur.
- `Fault`, `Overflow` and `Underflow` assert after the offending acceptance edge and remain set until `Reset`.

## Structure
- Shared package `a09_pkg` holds:
  - the 3-bit command encodings (CMD_NOP … CMD_VEC);
  - the FSM state encoding (IDLE, ISSUE, FAULT);
  - the default address width.
- Natural sub-module: `return_stack`, a synchronous LIFO with push, pop, full, empty and level outputs and parameterised width and depth, async active-low reset. The sequencer itself holds the FSM, the adder/mux and the flag registers.
- Top-level bench instantiates `pc_sequencer` driving the existing PC `Register` so the full loop is exercised.

## Test plan
- Reset then INC ×3, with the PC register starting at 0 → `LD` low for exactly one cycle per command; PC = 0001, 0002, 0003; `Ready` low in each ISSUE cycle.
- JMP 16'h00A0, then BRA 16'hFFF0 → PC = 00A0, then 0090. Then JMP FFFF followed by INC → PC wraps to 0000.
- CALL 0200 from PC 0010, CALL 0300, RET, RET → PC = 0200, 0300, 0201, 0011. `StackLevel` steps 1, 2, 1, 0.
- 8 CALLs fill the stack and a 9th CALL follows → first 8 load normally. The 9th does not assert `LD`, sets `Overflow` and `Fault`, and drops `Ready`. Further commands are ignored until `Reset`.
- RET on an empty stack after reset → `Underflow`=1, `Fault`=1, no load. Then `Reset` pulse → all flags 0, `Ready`=1, `StackLevel`=0.
- `Reset` asserted during the ISSUE cycle of JMP 0055 → `LD` rises at once and `NextPC`=0. After release, VEC loads ResetVector.
